// File: rtl/risc_pkg.sv
// ============================================================================
// Module : risc_pkg
// Brief  : Shared opcode map, phase encoding and widths for the 8-bit RISC core.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package risc_pkg;

    localparam int DATA_WIDTH   = 8;
    localparam int OPCODE_WIDTH = 3;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    localparam logic [2:0] PH_INST_ADDR  = 3'd0;
    localparam logic [2:0] PH_INST_FETCH = 3'd1;
    localparam logic [2:0] PH_INST_LOAD  = 3'd2;
    localparam logic [2:0] PH_IDLE       = 3'd3;
    localparam logic [2:0] PH_OP_ADDR    = 3'd4;
    localparam logic [2:0] PH_OP_FETCH   = 3'd5;
    localparam logic [2:0] PH_ALU_OP     = 3'd6;
    localparam logic [2:0] PH_STORE      = 3'd7;

    // Opcodes whose result comes back through the ALU into the accumulator.
    function automatic logic is_aluop(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

`default_nettype wire

// File: rtl/risc_phase_counter.sv
// ============================================================================
// Module : risc_phase_counter
// Brief  : 3-bit wrapping phase counter with enable and synchronous clear.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module risc_phase_counter
    import risc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic       i_clr,
    output logic [2:0] o_phase
);

    logic [2:0] r_phase;

    // Clear wins over enable so entering HALTED always parks the count at PH0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= PH_INST_ADDR;
        end else if (i_clr) begin
            r_phase <= PH_INST_ADDR;
        end else if (i_en) begin
            r_phase <= r_phase + 3'd1;
        end
    end

    assign o_phase = r_phase;

endmodule

`default_nettype wire

// File: rtl/risc_controller.sv
// ============================================================================
// Module : risc_controller
// Brief  : Eight-phase sequencer and control-strobe decoder with halt/resume.
//          Optional single-step gating in PH0 when RISC_CTRL_STEP_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module risc_controller #(
    parameter int OPCODE_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    zero,
    input  logic                    resume,
`ifdef RISC_CTRL_STEP_EN
    input  logic                    step,
`endif
    output logic                    sel,
    output logic                    rd,
    output logic                    ld_ir,
    output logic                    halt,
    output logic                    inc_pc,
    output logic                    ld_ac,
    output logic                    ld_pc,
    output logic                    wr,
    output logic                    data_e
);

    import risc_pkg::*;

    logic       r_halted;
    logic [2:0] w_phase;
    logic       w_is_hlt;
    logic       w_halt_entry;
    logic       w_advance;
    logic       w_alu;
    logic       w_sto;
    logic       w_jmp;
    logic       w_skz;

    assign w_is_hlt     = (opcode == OP_HLT);
    assign w_alu        = is_aluop(opcode);
    assign w_sto        = (opcode == OP_STO);
    assign w_jmp        = (opcode == OP_JMP);
    assign w_skz        = (opcode == OP_SKZ);
    assign w_halt_entry = !r_halted && (w_phase == PH_OP_ADDR) && w_is_hlt;

`ifdef RISC_CTRL_STEP_EN
    assign w_advance = !r_halted && ((w_phase != PH_INST_ADDR) || step);
`else
    assign w_advance = !r_halted;
`endif

    risc_phase_counter u_phase_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_advance),
        .i_clr   (w_halt_entry),
        .o_phase (w_phase)
    );

    // resume is only looked at once HALTED is registered, so a resume that
    // coincides with the HLT decode in PH4 cannot cancel the halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halted <= 1'b0;
        end else if (w_halt_entry) begin
            r_halted <= 1'b1;
        end else if (r_halted && resume) begin
            r_halted <= 1'b0;
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        halt   = 1'b0;
        inc_pc = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        if (r_halted) begin
            halt = 1'b1;
        end else begin
            case (w_phase)
                PH_INST_ADDR: begin
                    sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = w_is_hlt;
                end
                PH_OP_FETCH: begin
                    rd = w_alu;
                end
                PH_ALU_OP: begin
                    rd     = w_alu;
                    inc_pc = w_skz && zero;
                    ld_pc  = w_jmp;
                    data_e = w_sto;
                end
                default: begin
                    rd     = w_alu;
                    ld_ac  = w_alu;
                    inc_pc = w_jmp;
                    ld_pc  = w_jmp;
                    wr     = w_sto;
                    data_e = w_sto;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/risc_controller.md
Name: risc_controller

Overview:
- Eight-phase instruction sequencer for the 8-bit RISC core.
- Steps a 3-bit phase counter through fetch/decode/execute and decodes phase, the IR opcode and the ALU zero flag into the datapath control strobes: mux select, memory read/write, IR/AC/PC load, PC increment, data-bus enable.
- Owns the halted state and the resume handshake.
- Sits between the instruction register, ALU, program counter and memory interface.

Parameters:
- opcode_width, 3, width of the opcode field from the IR; decode assumes the 8-opcode map below.

Ports:
- clk      input   1  system clock, rising edge
- rst_n    input   1  asynchronous active-low reset
- opcode   input   3  IR opcode; must be stable from phase 3 through phase 7
- zero     input   1  ALU zero flag; sampled in phases 6–7
- resume   input   1  leaves HALTED; ignored in every other state
- sel      output  1  1 = address mux selects PC, 0 = IR operand address
- rd       output  1  memory read
- ld_ir    output  1  load instruction register
- halt     output  1  core halted / halting
- inc_pc   output  1  increment PC
- ld_ac    output  1  load accumulator from ALU
- ld_pc    output  1  load PC from IR operand
- wr       output  1  memory write
- data_e   output  1  drive AC onto data bus

Behaviour:
- Opcode map:
  - 000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP.
  - ALUOP = ADD | AND | XOR | LDA.
- States (registered): PH0 INST_ADDR .. PH7 STORE, plus HALTED. Encoding is 0..7 for phases, with a separate halted flag.
- Reset (async, rst_n=0): state=PH0, halted flag=0. Outputs follow PH0 decode: sel=1, all others 0.
- Sequencing:
  - Not halted: PHn -> PH(n+1) on every clk edge; PH7 -> PH0 (wrap).
  - One instruction takes exactly 8 cycles.
- Outputs are combinational decode of the registered state plus opcode/zero (Moore in phase, Mealy in opcode/zero). No glitch requirement beyond a single clock domain.
- Decode (unlisted outputs are 0):
  - PH0: sel=1
  - PH1: sel=1, rd=1
  - PH2: sel=1, rd=1, ld_ir=1
  - PH3: sel=1, rd=1, ld_ir=1
  - PH4: inc_pc=1; halt=(opcode==HLT)
  - PH5: rd=ALUOP
  - PH6: rd=ALUOP; inc_pc=(SKZ & zero); ld_pc=JMP; data_e=STO
  - PH7: rd=ALUOP; ld_ac=ALUOP; inc_pc=JMP; ld_pc=JMP; wr=STO; data_e=STO
- Halt:
  - In PH4 with opcode==HLT, the next edge enters HALTED (not PH5).
  - HALTED: halt=1, all other outputs 0, state held.
  - resume=1 sampled at an edge while HALTED -> PH0 next cycle.
  - A resume high for multiple cycles is harmless; re-halting needs a fresh HLT.
- resume asserted in the same cycle as PH4/HLT: ignored. HALTED is still entered; resume is acted on only once HALTED is registered.
- Reset mid-instruction or mid-HALTED returns to PH0 immediately. There is no partial-write protection; wr is deasserted asynchronously with reset.
- Unknown/undefined opcode width values: not applicable (full 3-bit decode); every opcode has defined strobes.

Optional Feature:
- Macro RISC_CTRL_STEP_EN.
- When defined:
  - Adds an input port step (1 bit).
  - The controller waits in PH0 until step=1 is sampled, then runs one full instruction and returns to PH0 to wait again.
  - HALTED behaviour is unchanged; resume returns to PH0, which then waits for step.
  - Outputs during the PH0 wait are the PH0 decode.
- When undefined: no step port; PH0 always advances.

Decomposition:
- Shared package risc_pkg holds:
  - opcode localparams (OP_HLT..OP_JMP)
  - phase localparams (PH_INST_ADDR..PH_STORE)
  - data_width=8, opcode_width=3
- Package is shared with the ALU and IR.
- One natural sub-module, risc_phase_counter: the 3-bit wrap counter with enable and sync clear. The controller owns the halted flag and the decode.

Test Plan:
- Reset then ADD (opcode=010), zero=0, 8 clocks:
  - sel=1 PH0–3; rd=1 PH1–3; ld_ir=1 PH2–3
  - inc_pc=1 PH4 only; rd=1 PH5–7; ld_ac=1 PH7 only
  - back in PH0 on cycle 9
- STO (110):
  - data_e=1 PH6–7, wr=1 PH7 only
  - rd=0 PH5–7, ld_ac=0 throughout
- SKZ (001):
  - with zero=1, inc_pc=1 in PH4 and PH6 (two increments)
  - with zero=0, inc_pc only in PH4
- JMP (111): ld_pc=1 PH6–7, inc_pc=1 PH4 and PH7, wr=0.
- HLT (000):
  - halt=1 in PH4, HALTED from next edge, all other outputs 0 for 20 cycles
  - resume=1 one cycle -> PH0 (sel=1) next cycle
  - resume asserted during PH4 itself -> still halts
- rst_n pulsed low in PH6 of STO -> wr/data_e drop immediately, state PH0 after release. With RISC_CTRL_STEP_EN, PH0 holds until step=1.
